au_div_seq: RTL
===============

Name: au_div_seq

Overview:
- Sequential unsigned restoring divider, one quotient bit per clock.
- Each iteration uses one AU_sub_cz instance of width WIDTH+1 with ci tied to 0. The co output selects restore or keep. The s output supplies the new partial remainder.
- Sits downstream of AU_sub_cz as its consumer. It is the arithmetic-unit divider used where a combinational array divider is too large.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- WIDTH, 8, word length of dividend, divisor, quotient and remainder (>= 1).
- ARCH, 0, prefix architecture passed unchanged to the AU_sub_cz instance (0 to 2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  divider can accept operands.
- a  input  WIDTH  dividend (unsigned).
- b  input  WIDTH  divisor (unsigned).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- q  output  WIDTH  quotient.
- r  output  WIDTH  remainder.
- dz  output  1  divide-by-zero flag (b == 0).

Behaviour:
- Reset and clock: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, q=0, r=0, dz=0, iteration counter=0.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: latch Q<=a, R<=0, D<=b, dz<=(b==0), cnt<=0; go to CALC.
- State CALC:
  - in_ready=0, out_valid=0.
  - Each cycle: minuend M={R,Q[WIDTH-1]} (WIDTH+1 bits); subtrahend {1'b0,D}; ci=0.
  - If co==1 (M<D): R<=M[WIDTH-1:0], quotient bit 0.
  - Else: R<=s[WIDTH-1:0], quotient bit 1.
  - Q<={Q[WIDTH-2:0],~co}. For WIDTH==1, Q<=~co.
  - cnt increments; after the cycle with cnt==WIDTH-1, go to DONE.
- State DONE:
  - out_valid=1, q=Q, r=R, dz held.
  - in_ready=0; in_valid is ignored.
  - On out_valid&out_ready: go to IDLE.
  - q, r and dz remain stable while out_valid=1 and out_ready=0.
- Latency:
  - Operand accept edge, then WIDTH CALC cycles.
  - out_valid rises on the edge ending the last CALC cycle, i.e. WIDTH+1 edges after the accept edge counted from the accept edge inclusive.
  - Throughput: one division per WIDTH+2 cycles minimum (accept, WIDTH CALC, 1 DONE with out_ready=1).
- Arithmetic invariant: R < D at every step when D != 0. Final a == q*b + r with r < b.
- Divide by zero:
  - No special path. The subtraction never borrows, so the result is naturally q = all ones and r = a.
  - dz=1; latency unchanged.
- Output register hold: q and r registers retain the last result in IDLE (not cleared).
  - Their value is only meaningful while out_valid=1.
- Reset mid-operation: rst_n low in any state aborts immediately to the reset values. The pending result is discarded.
- Out-of-sequence signals: operands changing while in CALC/DONE have no effect. out_ready outside DONE is ignored.

Test Plan:
- WIDTH=8: a=200, b=7, out_ready=1 -> out_valid exactly 9 edges after accept; q=28, r=4, dz=0; in_ready back to 1 one cycle later.
- WIDTH=8: a=55, b=0 -> q=255, r=55, dz=1, same latency as a nonzero divisor.
- WIDTH=8, boundaries:
  - a=3, b=9 -> q=0, r=3.
  - a=255, b=1 -> q=255, r=0.
  - a=255, b=255 -> q=1, r=0.
  - a=0, b=5 -> q=0, r=0.
- Backpressure: complete 100/3 with out_ready=0 for 5 cycles -> q=33, r=1 held stable, in_ready=0.
  - A new in_valid during the hold is ignored.
  - out_ready=1 -> handshake; next operands 9/2 give q=4, r=1.
- Reset in CALC: assert rst_n=0 after 3 CALC cycles -> out_valid=0, in_ready=1, q=r=0 immediately (asynchronously).
  - After release, 17/5 gives q=3, r=2.
- Random: 10k random pairs at WIDTH=1, 8 and 13, with ARCH=0/1/2 -> q==a/b and r==a%b (b!=0); q=all ones, r=a (b==0).

Source files
------------

// File: rtl/au_div_seq.sv
// Sequential unsigned restoring divider producing one quotient bit per clock.
// Also contains AU_sub_cz, the WIDTH-bit subtractor with borrow-out that
// performs the trial subtraction each iteration.

module AU_sub_cz #(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    // a - b - ci is computed as a + ~b + ~ci; co is the borrow (inverted carry).
    localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] g_s;
    logic [WIDTH-1:0] p_s;
    logic [WIDTH-1:0] gp_s;
    logic [WIDTH-1:0] pp_s;
    logic [WIDTH-1:0] c_s;
    logic             cin_s;
    logic             cout_s;

    assign g_s   = a & ~b;
    assign p_s   = ~(a ^ b);
    assign cin_s = ~ci;

    // Group generate/propagate prefix: ripple, Kogge-Stone or Sklansky by ARCH.
    always_comb begin
        logic [WIDTH-1:0] gv;
        logic [WIDTH-1:0] pv;
        logic [WIDTH-1:0] gn;
        logic [WIDTH-1:0] pn;
        int               j;
        gv = g_s;
        pv = p_s;
        gn = g_s;
        pn = p_s;
        j  = 0;
        if (ARCH == 0) begin
            for (int i = 1; i < WIDTH; i++) begin
                gv[i] = g_s[i] | (p_s[i] & gv[i-1]);
                pv[i] = p_s[i] & pv[i-1];
            end
        end else begin
            for (int l = 0; l < LEVELS; l++) begin
                gn = gv;
                pn = pv;
                for (int i = 0; i < WIDTH; i++) begin
                    if (ARCH == 1) begin
                        j = i - (32'sd1 <<< l);
                    end else if (((i >>> l) & 32'sd1) == 32'sd1) begin
                        j = ((i >>> l) <<< l) - 32'sd1;
                    end else begin
                        j = -32'sd1;
                    end
                    if (j >= 32'sd0) begin
                        gn[i] = gv[i] | (pv[i] & gv[j]);
                        pn[i] = pv[i] & pv[j];
                    end else begin
                        gn[i] = gv[i];
                        pn[i] = pv[i];
                    end
                end
                gv = gn;
                pv = pn;
            end
        end
        gp_s = gv;
        pp_s = pv;
    end

    // Per-bit carries from the group terms and the carry-in.
    always_comb begin
        c_s    = '0;
        c_s[0] = cin_s;
        for (int i = 1; i < WIDTH; i++) begin
            c_s[i] = gp_s[i-1] | (pp_s[i-1] & cin_s);
        end
        cout_s = gp_s[WIDTH-1] | (pp_s[WIDTH-1] & cin_s);
    end

    assign s  = p_s ^ c_s;
    assign co = ~cout_s;

endmodule

module au_div_seq #(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dz
);
    localparam int SW = WIDTH + 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [WIDTH-1:0]  quo_r;
    logic [WIDTH-1:0]  rem_r;
    logic [WIDTH-1:0]  den_r;
    logic [CW-1:0]     cnt_r;

    logic [SW-1:0]     minuend_s;
    logic [SW-1:0]     subtr_s;
    logic [SW-1:0]     diff_s;
    logic              borrow_s;
    logic [WIDTH-1:0]  rem_next_s;
    logic [WIDTH-1:0]  quo_next_s;
    logic              diff_msb_unused_s;

    // Shift the next dividend bit into the partial remainder and try D.
    assign minuend_s = {rem_r, quo_r[WIDTH-1]};
    assign subtr_s   = {1'b0, den_r};

    AU_sub_cz #(
        .WIDTH (SW),
        .ARCH  (ARCH)
    ) u_sub (
        .a  (minuend_s),
        .b  (subtr_s),
        .ci (1'b0),
        .s  (diff_s),
        .co (borrow_s)
    );

    // With R < D the difference always fits in WIDTH bits.
    assign diff_msb_unused_s = diff_s[WIDTH];

    // Restore on borrow, otherwise keep the difference.
    always_comb begin
        if (borrow_s) begin
            rem_next_s = minuend_s[WIDTH-1:0];
        end else begin
            rem_next_s = diff_s[WIDTH-1:0];
        end
    end

    generate
        if (WIDTH == 1) begin : g_q1
            assign quo_next_s = ~borrow_s;
        end else begin : g_qn
            assign quo_next_s = {quo_r[WIDTH-2:0], ~borrow_s};
        end
    endgenerate

    // Control FSM with the working registers and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
            dz        <= 1'b0;
            cnt_r     <= '0;
            quo_r     <= '0;
            rem_r     <= '0;
            den_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        quo_r    <= a;
                        rem_r    <= '0;
                        den_r    <= b;
                        dz       <= (b == '0);
                        cnt_r    <= '0;
                        in_ready <= 1'b0;
                        state_r  <= CALC;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                CALC: begin
                    quo_r <= quo_next_s;
                    rem_r <= rem_next_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == LAST) begin
                        q         <= quo_next_s;
                        r         <= rem_next_s;
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
